// File: rtl/cc_coef_loader.sv
// cc_coef_loader: double-buffered colour-correction coefficient bank.
// CSR writes land in a shadow bank while unlocked. Raising the lock arms a
// commit, and the next start-of-frame copies the whole shadow bank into the
// active bank so that a frame never sees a half-updated matrix.
// Optional build macro CC_COEF_LOADER_TIMEOUT_EN: a pending commit is forced
// through after TIMEOUT cycles when no start-of-frame arrives.
module cc_coef_loader #(
  parameter int unsigned COEF_CNT    = 12,
  parameter int unsigned COEF_W      = 32,
  parameter int unsigned COEF_FRAC_W = 16,
  parameter int unsigned TIMEOUT     = 1000000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       coef_lock_i,
  input  logic [3:0]                 coef_sel_i,
  input  logic [COEF_W-1:0]          coef_i,
  input  logic                       sof_i,
  output logic [COEF_CNT*COEF_W-1:0] coef_o,
  output logic                       pending_o,
  output logic                       applied_o,
  output logic                       cancel_o
);

  // 1.0 in the fixed-point coefficient format (matrix diagonal at reset)
  localparam logic [COEF_W-1:0] COEF_ONE = {{(COEF_W-1){1'b0}}, 1'b1} << COEF_FRAC_W;

  typedef enum logic [1:0] {
    ST_EDIT,
    ST_HOLD,
    ST_APPLIED
  } state_e;

  state_e            state_q;
  logic              lock_q;
  logic              pending_q;
  logic              applied_q;
  logic              cancel_q;
  logic [COEF_W-1:0] shadow_q [COEF_CNT];
  logic [COEF_W-1:0] active_q [COEF_CNT];

  logic              lock_rise;
  logic              lock_fall;
  logic              sel_valid;
  logic              timeout_hit;

  // Lock edge detection against the previous-cycle lock, plus index range check
  always_comb begin
    lock_rise = coef_lock_i & ~lock_q;
    lock_fall = ~coef_lock_i & lock_q;
    sel_valid = (32'(coef_sel_i) < COEF_CNT);
  end

`ifdef CC_COEF_LOADER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Saturating wait counter, cleared when a commit is armed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == ST_EDIT && lock_rise) begin
      cnt_q <= '0;
    end else if (state_q == ST_HOLD && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == ST_HOLD) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Commit FSM with shadow/active banks and registered status pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_EDIT;
      lock_q    <= 1'b0;
      pending_q <= 1'b0;
      applied_q <= 1'b0;
      cancel_q  <= 1'b0;
      for (int unsigned i = 0; i < COEF_CNT; i++) begin
        if (i == 0 || i == 4 || i == 8) begin
          shadow_q[i] <= COEF_ONE;
          active_q[i] <= COEF_ONE;
        end else begin
          shadow_q[i] <= '0;
          active_q[i] <= '0;
        end
      end
    end else begin
      lock_q    <= coef_lock_i;
      applied_q <= 1'b0;
      cancel_q  <= 1'b0;
      case (state_q)
        ST_EDIT: begin
          if (sel_valid) begin
            shadow_q[coef_sel_i] <= coef_i;
          end
          // sof_i is deliberately not looked at here, so an sof coinciding
          // with the lock rise cannot commit
          if (lock_rise) begin
            state_q   <= ST_HOLD;
            pending_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          // Unlocking takes priority over a coincident start-of-frame
          if (lock_fall) begin
            state_q   <= ST_EDIT;
            pending_q <= 1'b0;
            cancel_q  <= 1'b1;
          end else if (sof_i || timeout_hit) begin
            for (int unsigned i = 0; i < COEF_CNT; i++) begin
              active_q[i] <= shadow_q[i];
            end
            state_q   <= ST_APPLIED;
            pending_q <= 1'b0;
            applied_q <= 1'b1;
          end
        end
        ST_APPLIED: begin
          if (lock_fall) begin
            state_q <= ST_EDIT;
          end
        end
        default: begin
          state_q   <= ST_EDIT;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  // Flatten the active bank onto the output bus, index i at slot i
  always_comb begin
    coef_o = '0;
    for (int unsigned i = 0; i < COEF_CNT; i++) begin
      coef_o[i*COEF_W +: COEF_W] = active_q[i];
    end
  end

  assign pending_o = pending_q;
  assign applied_o = applied_q;
  assign cancel_o  = cancel_q;

endmodule

// File: doc/cc_coef_loader.md
CC_COEF_LOADER -- requirements
Module: cc_coef_loader

Interface
REQ-001 SHALL have parameter COEF_CNT, default 12, number of coefficients (3x3 matrix, indices 0..8, then offsets R,G,B at 9..11).
REQ-002 SHALL have parameter COEF_W, default 32, coefficient width in bits.
REQ-003 SHALL have parameter COEF_FRAC_W, default 16, fractional bits of the fixed-point coefficient format.
REQ-004 SHALL have parameter TIMEOUT, default 1000000, the number of cycles a commit may wait for start-of-frame.
REQ-005 SHALL have port clk_i, input, 1, clock.
REQ-006 SHALL have port rst_i, input, 1, reset (asynchronous, active-high).
REQ-007 SHALL have port coef_lock_i, input, 1, lock bit from the CSR block.
REQ-008 SHALL have port coef_sel_i, input, 4, coefficient index from the CSR block.
REQ-009 SHALL have port coef_i, input, COEF_W, coefficient value from the CSR block.
REQ-010 SHALL have port sof_i, input, 1, start-of-frame pulse (video tvalid & tready & tuser).
REQ-011 SHALL have port coef_o, output, COEF_CNT*COEF_W, active coefficient bank, index i at bits [(i+1)*COEF_W-1 -: COEF_W].
REQ-012 SHALL have port pending_o, output, 1, high while a commit waits for start-of-frame.
REQ-013 SHALL have port applied_o, output, 1, one-cycle pulse when the active bank is updated.
REQ-014 SHALL have port cancel_o, output, 1, one-cycle pulse when a pending commit is dropped.

Function
REQ-015 SHALL hold a shadow bank and an active bank, each COEF_CNT x COEF_W registers.
REQ-016 SHALL use a three-state FSM: EDIT, HOLD, APPLIED.
REQ-017 In EDIT, SHALL write shadow[coef_sel_i] <= coef_i every cycle when coef_sel_i < COEF_CNT; coef_sel_i >= COEF_CNT is ignored.
REQ-018 In HOLD and APPLIED, SHALL freeze the shadow bank.
REQ-019 SHALL detect a lock rise as coef_lock_i=1 with the previous-cycle registered value 0; a lock fall is the inverse.
REQ-020 EDIT -> HOLD on lock rise; the timeout counter SHALL be cleared to 0.
REQ-021 HOLD -> APPLIED on sof_i; active <= shadow as a whole bank in one cycle; applied_o SHALL pulse in the following cycle, aligned with the new coef_o.
REQ-022 An sof_i in the same cycle as the lock rise SHALL NOT commit; only an sof_i seen while in HOLD commits.
REQ-023 HOLD -> EDIT on lock fall; cancel_o SHALL pulse one cycle and the active bank SHALL be unchanged.
REQ-024 If a lock fall and sof_i occur in the same cycle in HOLD, cancel SHALL win.
REQ-025 APPLIED -> EDIT on lock fall, with no pulse.
REQ-026 APPLIED SHALL ignore sof_i.
REQ-027 pending_o SHALL be 1 exactly when the state is HOLD.
REQ-028 coef_o SHALL change only on an apply; there are no partial-bank updates.

Reset
REQ-029 On rst_i: state = EDIT; pending_o, applied_o and cancel_o = 0; the timeout counter = 0; the registered lock = 0.
REQ-030 On rst_i: shadow and active entries 0, 4 and 8 = 1 << COEF_FRAC_W (0x0001_0000 at defaults), and all other entries = 0, giving an identity pass-through.
REQ-031 A reset asserted in HOLD SHALL discard the commit; no applied_o or cancel_o pulse follows.

Configuration
REQ-032 With CC_COEF_LOADER_TIMEOUT_EN defined, the counter SHALL increment each cycle in HOLD (saturating).
REQ-033 With CC_COEF_LOADER_TIMEOUT_EN defined, when the counter reaches TIMEOUT-1 without sof_i, the block SHALL apply as in an sof_i commit (HOLD -> APPLIED, applied_o pulse).
REQ-034 Without CC_COEF_LOADER_TIMEOUT_EN, no counter logic SHALL be present and HOLD SHALL wait for sof_i indefinitely.

Verification
REQ-035 Reset release -> coef_o entries 0, 4 and 8 = 0x00010000, all others 0; pending_o = 0.
REQ-036 Apply: lock=0, sel=3, coef=0x00008000; then lock 0->1; sof_i 5 cycles later -> pending_o high 5 cycles, coef_o[3] = 0x00008000 one cycle after sof_i, applied_o pulse.
REQ-037 Cancel: lock rise, then lock fall before sof_i -> cancel_o pulse, coef_o unchanged, a later sof_i has no effect.
REQ-038 Simultaneous events: sof_i on the lock-rise cycle -> no apply; the next sof_i applies. Lock fall together with sof_i in HOLD -> cancel_o, no apply.
REQ-039 Shadow isolation: sel=12 with coef=0xFFFFFFFF in EDIT -> no shadow change; sel changes while locked -> shadow frozen.
REQ-040 Timeout (macro on, TIMEOUT=16): lock rise with no sof_i -> applied_o 16 cycles after HOLD entry. Macro off -> pending_o stays high.
